// File: rtl/tap_chain_sched_pkg.sv
// Shared types and helpers for tap_chain_sched: FSM encoding and source-id width.
package tap_chain_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ceil(log2(n)), never below 1 so a single-bit index always exists
  function automatic int src_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tap_chain_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the rotating pointer wins;
// the pointer moves past the winner only when the grant is actually taken.
module tap_chain_sched_rr_arbiter
  import tap_chain_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic                         enable,
  input  logic                         advance,
  output logic [NREQ-1:0]              grant,
  output logic [src_width(NREQ)-1:0]   grant_idx
);

  localparam int IW = src_width(NREQ);

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;

  always_comb begin
    int   k;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    k        = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        pick[k]  = 1'b1;
        pick_idx = IW'(k);
      end
    end
  end

  assign grant     = enable ? pick : '0;
  assign grant_idx = pick_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IW'(1);
    end
  end

endmodule

// File: rtl/tap_chain_sched.sv
// Round-robin scheduler feeding a collapsing 3-stage chain (a -> b -> o).
// Optional done counter enabled by TAP_CHAIN_SCHED_STATS_EN.
//
// Handshakes: a requester transfers when req_valid[k] & req_ready[k]; the
// consumer takes stage o when out_valid & out_ready. Valid never depends on
// ready of the same interface, and held data stays stable until taken.
module tap_chain_sched
  import tap_chain_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int SRCW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      tap_a,
  output logic                  tap_a_valid,
  output logic [WIDTH-1:0]      tap_b,
  output logic                  tap_b_valid,
  output logic                  busy,
  output logic [1:0]            inflight,
`ifdef TAP_CHAIN_SCHED_STATS_EN
  output logic [15:0]           done_cnt,
`endif
  output logic [1:0]            dbg_state
);

  localparam int IW = src_width(NREQ);

  state_t state, state_nx;

  logic             a_v, b_v, o_v;
  logic [WIDTH-1:0] a_d, b_d, o_d;
  logic [SRCW-1:0]  a_s, b_s, o_s;

  logic             o_free, b_move, a_move, in_free;
  logic             a_v_nx, b_v_nx, o_v_nx;
  logic             arb_en, take;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic [WIDTH-1:0] take_data;

  // Bubbles collapse: an empty stage always lets the one behind it advance.
  always_comb begin
    o_free  = !o_v || out_ready;
    b_move  = b_v && o_free;
    a_move  = a_v && (!b_v || b_move);
    in_free = !a_v || a_move;
  end

  assign take = |grant;

  always_comb begin
    a_v_nx = take || (a_v && !a_move);
    b_v_nx = a_move || (b_v && !b_move);
    o_v_nx = b_move || (o_v && !o_free);
  end

  always_comb begin
    take_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) take_data = req_data[k*WIDTH +: WIDTH];
    end
  end

  tap_chain_sched_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (arb_en),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid && !flush) state_nx = RUN;
      RUN: begin
        if (flush)                                       state_nx = DRAIN;
        else if (!(|req_valid) && !a_v && !b_v && !o_v)  state_nx = IDLE;
      end
      DRAIN:   if (!a_v_nx && !b_v_nx && !o_v_nx) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs; IDLE grants on the same cycle it leaves for RUN
  always_comb begin
    arb_en    = ((state == RUN) || (state == IDLE && |req_valid)) && in_free && !flush;
    busy      = a_v || b_v || o_v || (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_v      <= 1'b0;
      b_v      <= 1'b0;
      o_v      <= 1'b0;
      a_d      <= '0;
      b_d      <= '0;
      o_d      <= '0;
      a_s      <= '0;
      b_s      <= '0;
      o_s      <= '0;
      inflight <= 2'd0;
    end else begin
      a_v      <= a_v_nx;
      b_v      <= b_v_nx;
      o_v      <= o_v_nx;
      inflight <= {1'b0, a_v_nx} + {1'b0, b_v_nx} + {1'b0, o_v_nx};
      if (take) begin
        a_d <= take_data;
        a_s <= SRCW'(grant_idx);
      end
      if (a_move) begin
        b_d <= a_d;
        b_s <= a_s;
      end
      if (b_move) begin
        o_d <= b_d;
        o_s <= b_s;
      end
    end
  end

`ifdef TAP_CHAIN_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                    done_cnt <= 16'd0;
    else if (o_v && out_ready)  done_cnt <= done_cnt + 16'd1;
  end
`endif

  assign req_ready   = grant;
  assign out_valid   = o_v;
  assign out_data    = o_d;
  assign out_src     = o_s;
  assign tap_a       = a_d;
  assign tap_a_valid = a_v;
  assign tap_b       = b_d;
  assign tap_b_valid = b_v;

endmodule

// File: tb/tb_tap_chain_sched.sv
// Scoreboard bench for tap_chain_sched: items are tracked as an ordered list
// with chain positions, and outputs are popped from an expected queue.
module tb_tap_chain_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int SRCW  = 1;
  localparam int W     = WIDTH + SRCW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  flush = 1'b0;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SRCW-1:0]       out_src;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      tap_a;
  logic                  tap_a_valid;
  logic [WIDTH-1:0]      tap_b;
  logic                  tap_b_valid;
  logic                  busy;
  logic [1:0]            inflight;
  logic [1:0]            dbg_state;
`ifdef TAP_CHAIN_SCHED_STATS_EN
  logic [15:0]           done_cnt;
  int                    exp_done = 0;
`endif

  tap_chain_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .SRCW(SRCW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .tap_a       (tap_a),
    .tap_a_valid (tap_a_valid),
    .tap_b       (tap_b),
    .tap_b_valid (tap_b_valid),
    .busy        (busy),
    .inflight    (inflight),
`ifdef TAP_CHAIN_SCHED_STATS_EN
    .done_cnt    (done_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // reference model: items in age order, pos 0=a, 1=b, 2=o
  typedef struct {
    int               pos;
    logic [WIDTH-1:0] d;
    int               s;
  } item_t;

  item_t         chain[$];
  logic [W-1:0]  exp_q[$];
  int            m_state = 0;   // 0 idle, 1 run, 2 drain
  int            m_rr    = 0;
  int            n_chk   = 0;
  int            n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pops one expected item per output handshake
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected output %0h src %0d", out_data, out_src);
      end else begin
        e = exp_q.pop_front();
        if ({out_src, out_data} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got %0h expected %0h", {out_src, out_data}, e);
        end
      end
    end
  end

  // driver: one clock cycle of stimulus, model check and model update
  task automatic step(input logic [NREQ-1:0] rv, input logic [WIDTH-1:0] d0,
                      input logic [WIDTH-1:0] d1, input logic fl,
                      input logic ordy, input logic rs);
    bit in_free, en, ov, av, bv, fire;
    int g, k, lim, pre_size, p;
    logic [WIDTH-1:0] ad, bd;
    logic [WIDTH-1:0] dsel;
    req_valid = rv;
    req_data  = {d1, d0};
    flush     = fl;
    out_ready = ordy;
    rst       = rs;
    @(negedge clk);
    if (rs) begin
      chain.delete();
      exp_q.delete();
      m_state = 0;
      m_rr    = 0;
`ifdef TAP_CHAIN_SCHED_STATS_EN
      exp_done = 0;
`endif
    end else begin
      pre_size = chain.size();
      ov = (pre_size > 0) && (chain[0].pos == 2);
      av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
      foreach (chain[i]) begin
        if (chain[i].pos == 0) begin av = 1'b1; ad = chain[i].d; end
        if (chain[i].pos == 1) begin bv = 1'b1; bd = chain[i].d; end
      end
      // a collapsing chain can take new data unless all three stages are full and stuck
      in_free = (pre_size < 3) || ordy;
      en = ((m_state == 1) || (m_state == 0 && |rv)) && in_free && !fl;
      g = -1;
      if (en) begin
        for (int i = 0; i < NREQ; i++) begin
          k = (m_rr + i) % NREQ;
          if (g < 0 && rv[k]) g = k;
        end
      end
      chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(ov));
      if (ov) begin
        chk("out_data", 32'(out_data), 32'(chain[0].d));
        chk("out_src", 32'(out_src), 32'(chain[0].s));
      end
      chk("tap_a_valid", 32'(tap_a_valid), 32'(av));
      chk("tap_b_valid", 32'(tap_b_valid), 32'(bv));
      if (av) chk("tap_a", 32'(tap_a), 32'(ad));
      if (bv) chk("tap_b", 32'(tap_b), 32'(bd));
      chk("inflight", 32'(inflight), 32'(pre_size));
      chk("busy", 32'(busy), 32'((pre_size > 0) || (m_state != 0)));
      chk("state", 32'(dbg_state), 32'(m_state));
`ifdef TAP_CHAIN_SCHED_STATS_EN
      chk("done_cnt", 32'(done_cnt), 32'(exp_done));
`endif
      // advance the model across the coming edge
      fire = ov && ordy;
      if (fire) begin
        void'(chain.pop_front());
`ifdef TAP_CHAIN_SCHED_STATS_EN
        exp_done = (exp_done + 1) % 65536;
`endif
      end
      lim = 3;
      foreach (chain[i]) begin
        p = chain[i].pos + 1;
        if (p > lim - 1) p = lim - 1;
        chain[i].pos = p;
        lim = p;
      end
      if (g >= 0) begin
        dsel = (g == 0) ? d0 : d1;
        chain.push_back('{pos: 0, d: dsel, s: g});
        exp_q.push_back({SRCW'(g), dsel});
        m_rr = (g + 1) % NREQ;
      end
      case (m_state)
        0: if (|rv && !fl) m_state = 1;
        1: begin
          if (fl) m_state = 2;
          else if (!(|rv) && pre_size == 0) m_state = 0;
        end
        default: if (chain.size() == 0) m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'($urandom_range(0, 255));
  endfunction

  initial begin
    int pr, po, pf;
    // reset and reset-state checks
    repeat (3) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // single request, unstalled latency
    step(2'b01, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (5) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // round robin, full throughput
    repeat (8) step(2'b11, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    repeat (4) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // backpressure: fill, release one, hold, drain
    repeat (6) step(2'b11, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    step(2'b11, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    repeat (3) step(2'b11, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    repeat (6) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // bubble collapse under stall
    step(2'b01, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 8'h32, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (5) step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // flush during streaming; requests keep arriving while draining
    repeat (4) step(2'b11, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    step(2'b11, rnd(), rnd(), 1'b1, 1'b0, 1'b0);
    step(2'b11, rnd(), rnd(), 1'b1, 1'b1, 1'b0);
    repeat (5) step(2'b11, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    repeat (5) step(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // reset mid-stream with a full chain, then rr pointer must be back at 0
    repeat (2) step(2'b10, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    repeat (4) step(2'b11, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    step(2'b11, rnd(), rnd(), 1'b0, 1'b0, 1'b1);
    repeat (4) step(2'b11, rnd(), rnd(), 1'b0, 1'b1, 1'b0);

    // randomized phases with different load / backpressure mixes
    for (int ph = 0; ph < 4; ph++) begin
      pr = 30 + 20 * ph;
      po = 90 - 20 * ph;
      pf = (ph == 2) ? 8 : 2;
      for (int c = 0; c < 250; c++) begin
        logic [NREQ-1:0] rv;
        logic            rs;
        for (int b = 0; b < NREQ; b++) rv[b] = ($urandom_range(0, 99) < pr);
        rs = ($urandom_range(0, 199) == 0);
        step(rv, rnd(), rnd(), ($urandom_range(0, 99) < pf),
             rs ? 1'b0 : ($urandom_range(0, 99) < po), rs);
      end
    end

`ifdef TAP_CHAIN_SCHED_STATS_EN
    // counter wrap: 65536 outputs return done_cnt to 0
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 65536; c++) step(2'b01, rnd(), 8'h00, 1'b0, 1'b1, 1'b0);
`endif

    // bounded final drain
    for (int c = 0; c < 20 && (exp_q.size() != 0 || chain.size() != 0); c++)
      step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_chain_sched.md
Name: tap_chain_sched

Overview:
- Round-robin scheduler that shares one 3-stage register chain (in -> tap_a -> tap_b -> out) between NREQ requesters.
- Every intermediate stage value and valid is exposed as an output for observation.
- Sits between requester ports and a single downstream consumer.
- Sequences accept, advance, stall and drain of the chain.

Parameters:
WIDTH, 8, data width of every chain stage
NREQ, 2, number of requesters (2..8)
SRCW, 1, width of source id; must be >= clog2(NREQ), minimum 1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*WIDTH  packed request data; requester k at bits [k*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot accept strobe; a transfer occurs where req_valid&req_ready
flush  input  1  pulse: stop accepting new requests and drain the chain
out_valid  output  1  stage-o holds valid data
out_data  output  WIDTH  stage-o data
out_src  output  SRCW  requester index of stage-o data
out_ready  input  1  consumer accepts stage o when high with out_valid
tap_a  output  WIDTH  stage-a data
tap_a_valid  output  1  stage-a occupied
tap_b  output  WIDTH  stage-b data
tap_b_valid  output  1  stage-b occupied
busy  output  1  any stage occupied, or state != IDLE
inflight  output  2  count of occupied stages (0..3)

Behaviour:
- Reset: all valids 0; data/src regs 0; req_ready 0; state IDLE; rr pointer 0; inflight 0; busy 0.
- States:
  - IDLE: chain empty, no request.
  - RUN: accepting.
  - DRAIN: not accepting; exit to IDLE when the chain is empty.
- Transitions:
  - IDLE->RUN on any req_valid (flush low).
  - RUN->DRAIN on flush.
  - RUN->IDLE when no req_valid and chain empty.
  - DRAIN->IDLE when inflight==0 after the current cycle's advance.
  - flush in IDLE: stay IDLE.
  - flush in DRAIN: ignored.
- Advance rule, per stage, evaluated combinationally from the current state:
  - o frees when !out_valid or out_ready.
  - b moves to o when o frees.
  - a moves to b when b is empty or b moves.
  - Chain input is free when a is empty or a moves.
  - Bubbles collapse: an empty stage never blocks the stage behind it.
- Grant:
  - Issued in RUN, or in IDLE on the same cycle as the IDLE->RUN transition.
  - Requires the chain input to be free and flush low.
  - Pick the first valid requester starting at rr pointer, searching upward with wrap.
  - req_ready is combinational, one-hot, and never asserted where req_valid is 0.
  - On a grant, rr pointer <= granted+1 (wraps to 0 at NREQ).
- Latency: data accepted at edge N appears on tap_a after N, tap_b after N+1, out after N+2. This holds when unstalled, i.e. out_valid at cycle 3 after the accept cycle.
- Stall: out_valid stays asserted and out_data/out_src stay stable until out_ready; upstream stages hold when blocked.
- Full with out_ready=1 every cycle: one grant per cycle, throughput 1.
- inflight: popcount of the stage valids, registered consistently with them.
- Reset mid-operation: all in-flight data is discarded, no output handshake occurs, and the rr pointer returns to 0.

Optional Feature:
- Macro: TAP_CHAIN_SCHED_STATS_EN.
- Defined:
  - Adds output done_cnt [15:0].
  - Increments on each out_valid&out_ready.
  - Wraps 0xFFFF->0.
  - Reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tap_chain_sched_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Function computing source-id width from NREQ, clamped to a minimum of 1.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, enable, advance.
  - Outputs: one-hot grant, grant index.
  - Holds the rotating pointer.
- Top level: stage registers, advance logic and FSM.

Test Plan:
- Single request: NREQ=2, req_valid=2'b01, data 0xA5 for 1 cycle, out_ready=1 -> tap_a=0xA5 next cycle, tap_b the cycle after, out_valid with out_data=0xA5 and out_src=0 three cycles after accept, then inflight=0 and busy=0.
- Round robin: both requesters valid continuously with data 0x11/0x22 -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1; one output per cycle.
- Backpressure: out_ready=0 with continuous requests -> chain fills after 3 accepts, req_ready=0, inflight=3. Raise out_ready for 1 cycle -> exactly one output and one new accept; order preserved.
- Bubble collapse: accept, idle 1 cycle, accept, with out_ready=0 -> after 4 cycles all three stages are not yet full, then both items are in o/b with no gap; inflight=2.
- Flush: pulse flush during streaming -> no req_ready while in DRAIN, remaining items exit in order, state returns to IDLE and busy deasserts when inflight hits 0.
- Reset mid-stream: assert rst with inflight=3 -> next cycle all valids 0, inflight=0, rr pointer 0. With STATS_EN, done_cnt=0, and after 0xFFFF+1 outputs done_cnt reads 0.
